// File: rtl/clk_time_pkg.sv
// =============================================================================
// Package     : clk_time_pkg
// Description : Shared definitions for the time setter: edit-state encoding,
//               field-select codes, weekday codes and calendar helper functions.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package clk_time_pkg;

  // The SET_* encodings equal the field-select codes, so the registered
  // field_sel output can be taken straight from the next state.
  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_YEAR = 3'd1,
    ST_SET_MON  = 3'd2,
    ST_SET_DAY  = 3'd3,
    ST_SET_HOUR = 3'd4,
    ST_SET_MIN  = 3'd5,
    ST_SET_SEC  = 3'd6
  } state_e;

  localparam logic [2:0] FS_NONE = 3'd0;
  localparam logic [2:0] FS_YEAR = 3'd1;
  localparam logic [2:0] FS_MON  = 3'd2;
  localparam logic [2:0] FS_DAY  = 3'd3;
  localparam logic [2:0] FS_HOUR = 3'd4;
  localparam logic [2:0] FS_MIN  = 3'd5;
  localparam logic [2:0] FS_SEC  = 3'd6;

  localparam logic [3:0] WD_MON = 4'd1;
  localparam logic [3:0] WD_TUE = 4'd2;
  localparam logic [3:0] WD_WED = 4'd3;
  localparam logic [3:0] WD_THU = 4'd4;
  localparam logic [3:0] WD_FRI = 4'd5;
  localparam logic [3:0] WD_SAT = 4'd6;
  localparam logic [3:0] WD_SUN = 4'd7;

  localparam logic [3:0] MODE_RUN = 4'd1;
  localparam logic [3:0] MODE_SET = 4'd0;

  // Gregorian leap year rule.
  function automatic logic is_leap(input logic [14:0] year);
    return ((year % 15'd4) == 15'd0) &&
           (((year % 15'd100) != 15'd0) || ((year % 15'd400) == 15'd0));
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                               input logic [14:0] year);
    logic [4:0] dim;
    case (month)
      4'd2:                    dim = is_leap(year) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      default:                 dim = 5'd31;
    endcase
    return dim;
  endfunction

endpackage

`default_nettype wire

// File: rtl/weekday_calc.sv
// =============================================================================
// Module      : weekday_calc
// Description : Combinational day-of-week (Sakamoto's method).
//   year_i  in  15  Gregorian year (>= 1)
//   month_i in  4   month 1..12
//   day_i   in  5   day 1..31
//   week_o  out 4   weekday, Mon=1 .. Sun=7
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module weekday_calc
  import clk_time_pkg::*;
(
  input  logic [14:0] year_i,
  input  logic [3:0]  month_i,
  input  logic [4:0]  day_i,
  output logic [3:0]  week_o
);

  logic [15:0] y;
  logic [3:0]  t;
  logic [16:0] sum;
  logic [2:0]  dow;

  always_comb begin
    // Jan/Feb are treated as months of the previous year.
    y = {1'b0, year_i} - {15'd0, (month_i < 4'd3)};
    case (month_i)
      4'd1:    t = 4'd0;
      4'd2:    t = 4'd3;
      4'd3:    t = 4'd2;
      4'd4:    t = 4'd5;
      4'd5:    t = 4'd0;
      4'd6:    t = 4'd3;
      4'd7:    t = 4'd5;
      4'd8:    t = 4'd1;
      4'd9:    t = 4'd4;
      4'd10:   t = 4'd6;
      4'd11:   t = 4'd2;
      4'd12:   t = 4'd4;
      default: t = 4'd0;
    endcase
    sum = {1'b0, y} + 17'(y / 16'd4) - 17'(y / 16'd100) + 17'(y / 16'd400)
        + {13'd0, t} + {12'd0, day_i};
    // Result 0 is Sunday.
    dow = 3'(sum % 17'd7);
    week_o = (dow == 3'd0) ? WD_SUN : {1'b0, dow};
  end

endmodule

`default_nettype wire

// File: rtl/time_setter.sv
// =============================================================================
// Module      : time_setter
// Description : Button-driven calendar/time editor producing the load bus for
//               the time keeper. RUN drives mode=1 (keeper free-runs); SET
//               drives mode=0 (keeper loads the edited values). Entering SET
//               captures the keeper's live time, clamped to legal ranges.
//   clk, rst_n                 clock, synchronous active-low reset
//   btn_mode/next/up/down  in  debounced button levels (rising edge acts)
//   cur_year..cur_sec      in  live time from the keeper
//   year_d..sec_d          out edited date/time
//   week_s                 out weekday of edited date, Mon=1..Sun=7
//   mode                   out 1 RUN, 0 SET
//   field_sel              out selected field, 0 in RUN
// Configuration macro: TIME_SETTER_AUTO_REPEAT_EN enables auto-repeat of held
//   up/down buttons (REPEAT_DLY first step, then every REPEAT_PER cycles).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module time_setter
  import clk_time_pkg::*;
#(
  parameter int unsigned DEF_YEAR   = 2023,
  parameter int unsigned DEF_MONTH  = 5,
  parameter int unsigned DEF_DAY    = 9,
  parameter int unsigned DEF_HOUR   = 11,
  parameter int unsigned DEF_MIN    = 59,
  parameter int unsigned DEF_SEC    = 58,
  parameter int unsigned YEAR_MIN   = 1,
  parameter int unsigned YEAR_MAX   = 9999,
  parameter int unsigned REPEAT_DLY = 50_000_000,
  parameter int unsigned REPEAT_PER = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [15:0] cur_year,
  input  logic [5:0]  cur_month,
  input  logic [10:0] cur_day,
  input  logic [10:0] cur_hour,
  input  logic [10:0] cur_min,
  input  logic [10:0] cur_sec,
  output logic [14:0] year_d,
  output logic [3:0]  month_d,
  output logic [4:0]  day_d,
  output logic [5:0]  hour_d,
  output logic [5:0]  min_d,
  output logic [5:0]  sec_d,
  output logic [3:0]  week_s,
  output logic [3:0]  mode,
  output logic [2:0]  field_sel
);

  localparam logic [14:0] YMIN = 15'(YEAR_MIN);
  localparam logic [14:0] YMAX = 15'(YEAR_MAX);

  // Parameter sanity: the repeat reload value is REPEAT_DLY - REPEAT_PER.
  if (REPEAT_PER == 0 || REPEAT_PER > REPEAT_DLY || YEAR_MIN == 0 ||
      YEAR_MIN > YEAR_MAX) begin : g_bad_params
    $error("time_setter: illegal parameter combination");
  end

  state_e      state_q, state_d;
  logic        btn_mode_q, btn_next_q, btn_up_q, btn_down_q;
  logic [14:0] ed_year_q,  ed_year_d;
  logic [3:0]  ed_month_q, ed_month_d;
  logic [4:0]  ed_day_q,   ed_day_d;
  logic [5:0]  ed_hour_q,  ed_hour_d;
  logic [5:0]  ed_min_q,   ed_min_d;
  logic [5:0]  ed_sec_q,   ed_sec_d;
  logic [3:0]  week_q,     week_d;
  logic [3:0]  mode_q,     mode_d;
  logic [2:0]  field_q,    field_d;

  logic        e_mode, e_next, e_up, e_down;
  logic        rpt_up, rpt_dn, step_up, step_dn;
  logic [14:0] cap_year;
  logic [3:0]  cap_month;
  logic [4:0]  cap_day, cap_dim, dim_cur;
  logic [5:0]  cap_hour, cap_min, cap_sec;

  assign e_mode = btn_mode & ~btn_mode_q;
  assign e_next = btn_next & ~btn_next_q;
  assign e_up   = btn_up   & ~btn_up_q;
  assign e_down = btn_down & ~btn_down_q;

`ifdef TIME_SETTER_AUTO_REPEAT_EN
  logic [31:0] rpt_cnt_q, rpt_cnt_d;
  logic        held_up, held_dn, rpt_fire;

  always_comb begin
    held_up   = btn_up & btn_up_q & ~btn_down;
    held_dn   = btn_down & btn_down_q & ~btn_up;
    rpt_cnt_d = '0;
    rpt_fire  = 1'b0;
    if ((state_q != ST_RUN) && !e_mode && !e_next && (held_up | held_dn)) begin
      if (rpt_cnt_q + 32'd1 == 32'(REPEAT_DLY)) begin
        rpt_fire  = 1'b1;
        // Reload so the next step lands REPEAT_PER cycles later.
        rpt_cnt_d = 32'(REPEAT_DLY) - 32'(REPEAT_PER);
      end else begin
        rpt_cnt_d = rpt_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rpt_cnt_q <= '0;
    else        rpt_cnt_q <= rpt_cnt_d;
  end

  assign rpt_up = rpt_fire & held_up;
  assign rpt_dn = rpt_fire & held_dn;
`else
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  // Simultaneous up and down edges cancel.
  assign step_up = (e_up & ~e_down) | rpt_up;
  assign step_dn = (e_down & ~e_up) | rpt_dn;

  // Live time clamped into legal ranges for capture on SET entry.
  always_comb begin
    cap_year  = (cur_year < 16'(YEAR_MIN)) ? YMIN :
                (cur_year > 16'(YEAR_MAX)) ? YMAX : cur_year[14:0];
    cap_month = (cur_month == 6'd0) ? 4'd1 :
                (cur_month > 6'd12) ? 4'd12 : cur_month[3:0];
    cap_dim   = days_in_month(cap_month, cap_year);
    cap_day   = (cur_day == 11'd0) ? 5'd1 :
                (cur_day > {6'd0, cap_dim}) ? cap_dim : cur_day[4:0];
    cap_hour  = (cur_hour > 11'd23) ? 6'd23 : cur_hour[5:0];
    cap_min   = (cur_min  > 11'd59) ? 6'd59 : cur_min[5:0];
    cap_sec   = (cur_sec  > 11'd59) ? 6'd59 : cur_sec[5:0];
  end

  weekday_calc u_weekday (
    .year_i  (ed_year_q),
    .month_i (ed_month_q),
    .day_i   (ed_day_q),
    .week_o  (week_d)
  );

  always_comb begin
    state_d    = state_q;
    ed_year_d  = ed_year_q;
    ed_month_d = ed_month_q;
    ed_day_d   = ed_day_q;
    ed_hour_d  = ed_hour_q;
    ed_min_d   = ed_min_q;
    ed_sec_d   = ed_sec_q;
    dim_cur    = days_in_month(ed_month_q, ed_year_q);

    if (e_mode) begin
      if (state_q == ST_RUN) begin
        state_d    = ST_SET_YEAR;
        ed_year_d  = cap_year;
        ed_month_d = cap_month;
        ed_day_d   = cap_day;
        ed_hour_d  = cap_hour;
        ed_min_d   = cap_min;
        ed_sec_d   = cap_sec;
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q != ST_RUN) begin
      if (e_next) begin
        case (state_q)
          ST_SET_YEAR: state_d = ST_SET_MON;
          ST_SET_MON:  state_d = ST_SET_DAY;
          ST_SET_DAY:  state_d = ST_SET_HOUR;
          ST_SET_HOUR: state_d = ST_SET_MIN;
          ST_SET_MIN:  state_d = ST_SET_SEC;
          default:     state_d = ST_SET_YEAR;
        endcase
      end else if (step_up ^ step_dn) begin
        case (state_q)
          ST_SET_YEAR: begin
            if (step_up) ed_year_d = (ed_year_q >= YMAX) ? YMIN : ed_year_q + 15'd1;
            else         ed_year_d = (ed_year_q <= YMIN) ? YMAX : ed_year_q - 15'd1;
            if (ed_day_q > days_in_month(ed_month_q, ed_year_d))
              ed_day_d = days_in_month(ed_month_q, ed_year_d);
          end
          ST_SET_MON: begin
            if (step_up) ed_month_d = (ed_month_q >= 4'd12) ? 4'd1 : ed_month_q + 4'd1;
            else         ed_month_d = (ed_month_q <= 4'd1) ? 4'd12 : ed_month_q - 4'd1;
            if (ed_day_q > days_in_month(ed_month_d, ed_year_q))
              ed_day_d = days_in_month(ed_month_d, ed_year_q);
          end
          ST_SET_DAY: begin
            if (step_up) ed_day_d = (ed_day_q >= dim_cur) ? 5'd1 : ed_day_q + 5'd1;
            else         ed_day_d = (ed_day_q <= 5'd1) ? dim_cur : ed_day_q - 5'd1;
          end
          ST_SET_HOUR: begin
            if (step_up) ed_hour_d = (ed_hour_q >= 6'd23) ? 6'd0 : ed_hour_q + 6'd1;
            else         ed_hour_d = (ed_hour_q == 6'd0) ? 6'd23 : ed_hour_q - 6'd1;
          end
          ST_SET_MIN: begin
            if (step_up) ed_min_d = (ed_min_q >= 6'd59) ? 6'd0 : ed_min_q + 6'd1;
            else         ed_min_d = (ed_min_q == 6'd0) ? 6'd59 : ed_min_q - 6'd1;
          end
          default: begin
            if (step_up) ed_sec_d = (ed_sec_q >= 6'd59) ? 6'd0 : ed_sec_q + 6'd1;
            else         ed_sec_d = (ed_sec_q == 6'd0) ? 6'd59 : ed_sec_q - 6'd1;
          end
        endcase
      end
    end

    mode_d  = (state_d == ST_RUN) ? MODE_RUN : MODE_SET;
    field_d = 3'(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      btn_mode_q <= 1'b0;
      btn_next_q <= 1'b0;
      btn_up_q   <= 1'b0;
      btn_down_q <= 1'b0;
      ed_year_q  <= 15'(DEF_YEAR);
      ed_month_q <= 4'(DEF_MONTH);
      ed_day_q   <= 5'(DEF_DAY);
      ed_hour_q  <= 6'(DEF_HOUR);
      ed_min_q   <= 6'(DEF_MIN);
      ed_sec_q   <= 6'(DEF_SEC);
      week_q     <= WD_TUE;
      mode_q     <= MODE_RUN;
      field_q    <= FS_NONE;
    end else begin
      state_q    <= state_d;
      btn_mode_q <= btn_mode;
      btn_next_q <= btn_next;
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
      ed_year_q  <= ed_year_d;
      ed_month_q <= ed_month_d;
      ed_day_q   <= ed_day_d;
      ed_hour_q  <= ed_hour_d;
      ed_min_q   <= ed_min_d;
      ed_sec_q   <= ed_sec_d;
      week_q     <= week_d;
      mode_q     <= mode_d;
      field_q    <= field_d;
    end
  end

  assign year_d    = ed_year_q;
  assign month_d   = ed_month_q;
  assign day_d     = ed_day_q;
  assign hour_d    = ed_hour_q;
  assign min_d     = ed_min_q;
  assign sec_d     = ed_sec_q;
  assign week_s    = week_q;
  assign mode      = mode_q;
  assign field_sel = field_q;

endmodule

`default_nettype wire

// File: tb/tb_time_setter.sv
// =============================================================================
// Module      : tb_time_setter
// Description : Self-checking bench for time_setter (default build): directed
//               vector table, hand-written corner sequences and randomized
//               button/live-time stimulus against a calendar reference model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_time_setter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [15:0] cur_year = 16'd2000;
  logic [5:0]  cur_month = 6'd1;
  logic [10:0] cur_day = 11'd1, cur_hour = 11'd0, cur_min = 11'd0, cur_sec = 11'd0;
  logic [14:0] year_d;
  logic [3:0]  month_d;
  logic [4:0]  day_d;
  logic [5:0]  hour_d, min_d, sec_d;
  logic [3:0]  week_s, mode;
  logic [2:0]  field_sel;

  always #5 clk = ~clk;

  time_setter dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .year_d(year_d), .month_d(month_d), .day_d(day_d), .hour_d(hour_d),
    .min_d(min_d), .sec_d(sec_d), .week_s(week_s), .mode(mode), .field_sel(field_sel)
  );

  int n_pass = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  int m_y, m_mo, m_d, m_h, m_mi, m_s, m_wk, m_fld;
  bit m_set, pm, pn, pu, pd;

  function automatic bit leap(int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int dim(int mo, int y);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    return t[mo-1] + ((mo == 2 && leap(y)) ? 1 : 0);
  endfunction

  // Day count from 0001-01-01 (a Monday).
  function automatic int wday(int y, int mo, int d);
    int cum[12] = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};
    int n;
    n = 365*(y-1) + (y-1)/4 - (y-1)/100 + (y-1)/400 + cum[mo-1] + d;
    if (mo > 2 && leap(y)) n++;
    return ((n - 1) % 7) + 1;
  endfunction

  task automatic model_reset();
    m_y = 2023; m_mo = 5; m_d = 9; m_h = 11; m_mi = 59; m_s = 58;
    m_wk = 2; m_set = 1'b0; m_fld = 0; pm = 0; pn = 0; pu = 0; pd = 0;
  endtask

  task automatic model_clk(input bit bm, input bit bn, input bit bu, input bit bd);
    bit em, en, eu, ed;
    int nw, delta;
    em = bm && !pm; en = bn && !pn; eu = bu && !pu; ed = bd && !pd;
    nw = wday(m_y, m_mo, m_d);
    if (em) begin
      if (!m_set) begin
        m_y  = int'(cur_year);  if (m_y < 1) m_y = 1; if (m_y > 9999) m_y = 9999;
        m_mo = int'(cur_month); if (m_mo < 1) m_mo = 1; if (m_mo > 12) m_mo = 12;
        m_d  = int'(cur_day);   if (m_d < 1) m_d = 1; if (m_d > dim(m_mo, m_y)) m_d = dim(m_mo, m_y);
        m_h  = int'(cur_hour);  if (m_h > 23) m_h = 23;
        m_mi = int'(cur_min);   if (m_mi > 59) m_mi = 59;
        m_s  = int'(cur_sec);   if (m_s > 59) m_s = 59;
        m_set = 1'b1; m_fld = 1;
      end else begin
        m_set = 1'b0;
      end
    end else if (m_set && en) begin
      m_fld = (m_fld % 6) + 1;
    end else if (m_set && (eu != ed)) begin
      delta = eu ? 1 : -1;
      case (m_fld)
        1: begin
          m_y += delta; if (m_y > 9999) m_y = 1; if (m_y < 1) m_y = 9999;
          if (m_d > dim(m_mo, m_y)) m_d = dim(m_mo, m_y);
        end
        2: begin
          m_mo += delta; if (m_mo > 12) m_mo = 1; if (m_mo < 1) m_mo = 12;
          if (m_d > dim(m_mo, m_y)) m_d = dim(m_mo, m_y);
        end
        3: begin
          m_d += delta; if (m_d > dim(m_mo, m_y)) m_d = 1; if (m_d < 1) m_d = dim(m_mo, m_y);
        end
        4: m_h  = (m_h + delta + 24) % 24;
        5: m_mi = (m_mi + delta + 60) % 60;
        default: m_s = (m_s + delta + 60) % 60;
      endcase
    end
    m_wk = nw;
    pm = bm; pn = bn; pu = bu; pd = bd;
  endtask

  function automatic logic [63:0] mk_vec(int y, int mo, int d, int h, int mi, int s,
                                         int wk, int md, int fs);
    return {11'd0, 15'(y), 4'(mo), 5'(d), 6'(h), 6'(mi), 6'(s), 4'(wk), 4'(md), 3'(fs)};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {11'd0, year_d, month_d, day_d, hour_d, min_d, sec_d, week_s, mode, field_sel};
  endfunction

  function automatic logic [63:0] model_vec();
    return mk_vec(m_y, m_mo, m_d, m_h, m_mi, m_s, m_wk, m_set ? 0 : 1, m_set ? m_fld : 0);
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic chk_vec(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (y/mo/d/h/mi/s/wk/mode/fs packed)", nm, act, exp);
  endtask

  // ---------------- stimulus ----------------
  task automatic set_cur(input int y, input int mo, input int d, input int h,
                         input int mi, input int s);
    cur_year = 16'(y); cur_month = 6'(mo); cur_day = 11'(d);
    cur_hour = 11'(h); cur_min = 11'(mi); cur_sec = 11'(s);
  endtask

  task automatic tick(input bit bm, input bit bn, input bit bu, input bit bd);
    @(negedge clk);
    btn_mode = bm; btn_next = bn; btn_up = bu; btn_down = bd;
    @(posedge clk);
    model_clk(bm, bn, bu, bd);
    #1;
    chk_vec("model", dut_vec(), model_vec());
  endtask

  task automatic press(input bit bm, input bit bn, input bit bu, input bit bd);
    tick(bm, bn, bu, bd);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_mode = 1'b0; btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    chk_vec("reset_state", dut_vec(), mk_vec(2023, 5, 9, 11, 59, 58, 2, 1, 0));
  endtask

  typedef struct {
    bit m, n, u, d;
    int y, mo, dd, h, mi, s, wk, md, fs;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0, 2024,2,29,10,0,0, 4,0,1};
    tbl[1]  = '{1'b0,1'b0,1'b1,1'b0, 2025,2,28,10,0,0, 5,0,1};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b1, 2024,2,28,10,0,0, 3,0,1};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0, 2024,2,28,10,0,0, 3,0,2};
    tbl[4]  = '{1'b0,1'b0,1'b1,1'b0, 2024,3,28,10,0,0, 4,0,2};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b0, 2024,3,28,10,0,0, 4,0,3};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b0, 2024,3,29,10,0,0, 5,0,3};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b0, 2024,3,29,10,0,0, 5,0,4};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b1, 2024,3,29,10,0,0, 5,0,4};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b0, 2024,3,29,11,0,0, 5,0,4};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b1, 2024,3,29,10,0,0, 5,0,4};
    tbl[11] = '{1'b0,1'b1,1'b0,1'b0, 2024,3,29,10,0,0, 5,0,5};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b1, 2024,3,29,10,59,0, 5,0,5};
    tbl[13] = '{1'b0,1'b1,1'b0,1'b0, 2024,3,29,10,59,0, 5,0,6};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b1, 2024,3,29,10,59,59, 5,0,6};
    tbl[15] = '{1'b0,1'b0,1'b1,1'b0, 2024,3,29,10,59,0, 5,0,6};
    tbl[16] = '{1'b0,1'b1,1'b0,1'b0, 2024,3,29,10,59,0, 5,0,1};
    tbl[17] = '{1'b1,1'b0,1'b0,1'b0, 2024,3,29,10,59,0, 5,1,0};
    tbl[18] = '{1'b0,1'b0,1'b1,1'b0, 2024,3,29,10,59,0, 5,1,0};
    tbl[19] = '{1'b0,1'b1,1'b0,1'b0, 2024,3,29,10,59,0, 5,1,0};

    // Reset values and one-cycle latency of capture / week_s.
    do_reset();
    chk("reset_mode", int'(mode), 1);
    chk("reset_field", int'(field_sel), 0);
    chk("reset_week", int'(week_s), 2);
    set_cur(2024, 2, 29, 10, 0, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("enter_mode", int'(mode), 0);
    chk("enter_field", int'(field_sel), 1);
    chk("enter_year", int'(year_d), 2024);
    chk("enter_day", int'(day_d), 29);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("yr_up_year", int'(year_d), 2025);
    chk("yr_up_day", int'(day_d), 28);
    chk("yr_up_week_lag", int'(week_s), 4);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("yr_up_week", int'(week_s), 5);

    // Directed vector table.
    do_reset();
    set_cur(2024, 2, 29, 10, 0, 0);
    for (int i = 0; i < 20; i++) begin
      press(tbl[i].m, tbl[i].n, tbl[i].u, tbl[i].d);
      chk_vec($sformatf("table%0d", i), dut_vec(),
              mk_vec(tbl[i].y, tbl[i].mo, tbl[i].dd, tbl[i].h, tbl[i].mi, tbl[i].s,
                     tbl[i].wk, tbl[i].md, tbl[i].fs));
    end

    // Month editing with day clamp and wrap.
    do_reset();
    set_cur(2023, 3, 31, 12, 0, 0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    chk("mar31_down_month", int'(month_d), 2);
    chk("mar31_down_day", int'(day_d), 28);
    repeat (10) press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("month_up10", int'(month_d), 12);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("month_wrap", int'(month_d), 1);

    // mode+up together in SET_HOUR exits without editing.
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    chk("at_hour_field", int'(field_sel), 4);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    chk("mode_up_mode", int'(mode), 1);
    chk("mode_up_hour", int'(hour_d), 12);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Seconds wrap, field cycling and exit holding values.
    press(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) press(1'b0, 1'b1, 1'b0, 1'b0);
    chk("at_sec_field", int'(field_sel), 6);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sec_wrap_down", int'(sec_d), 59);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    chk("next_wraps_to_year", int'(field_sel), 1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("exit_mode", int'(mode), 1);
    chk("exit_sec_held", int'(sec_d), 59);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // up+down together, then reset mid-edit.
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b1);
    chk("updown_year", int'(year_d), 2023);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre_reset_year", int'(year_d), 2024);
    do_reset();
    chk("midedit_reset_year", int'(year_d), 2023);
    chk("midedit_reset_mode", int'(mode), 1);

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 9) == 0)
        set_cur(int'($urandom_range(0, 10500)), int'($urandom_range(0, 14)),
                int'($urandom_range(0, 33)), int'($urandom_range(0, 25)),
                int'($urandom_range(0, 61)), int'($urandom_range(0, 61)));
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
